// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding decode. It issues in-order word fetches to
// instruction memory, buffers the returned words in a small circular queue,
// and presents the oldest buffered word to decode. It follows decode's stall,
// redirects on the execute flush, and stops fetching after a consumed halt.
//
// Parameters
//   RESET_PC : fetch address after reset
//   QDEPTH   : queue entries; also caps the number of requests in flight
//              (buffered + outstanding + stale-outstanding <= QDEPTH)
//
// Ports
//   i_clk, i_rst           : clock, synchronous active-high reset
//   o_imem_req/o_imem_addr : fetch request and word-aligned address
//   i_imem_ready           : memory accepts the request this cycle
//   i_imem_rvalid/rdata    : in-order response for the oldest open request
//   i_stall                : decode holds the current output
//   i_redirect/_pc         : execute flush and its target PC
//   i_halt                 : decode sees a halt opcode on o_inst
//   o_inst/o_pc/o_valid    : instruction presented to decode
//
// Handshakes
//   A fetch transfers on any cycle where o_imem_req and i_imem_ready are both
//   high. o_imem_req is recomputed every cycle and may drop without a
//   transfer (redirect, halt, queue full). i_imem_rvalid has no back-pressure:
//   every response is taken in the cycle it arrives. Decode takes o_inst on
//   any cycle where o_valid is high and neither i_stall nor i_redirect is.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
  localparam logic [CW+1:0] CAP  = (CW + 2)'(QDEPTH);

  logic [31:0]       fetch_pc;
  logic [31:0]       q_pc   [QDEPTH];
  logic [31:0]       q_inst [QDEPTH];
  logic [QDEPTH-1:0] q_filled;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     fill_ptr;   // oldest allocated entry still waiting for data
  logic [CW-1:0]     count;      // allocated entries (filled or not)
  logic [CW-1:0]     pend_cnt;   // allocated entries not yet filled
  logic [CW-1:0]     drop_cnt;   // stale responses still owed by memory
  logic              halted;

  logic              cons;
  logic              accept;
  logic              fill;
  logic [CW+1:0]     occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = ~i_rst & (count != '0) & q_filled[head];
  assign o_inst  = q_inst[head];
  assign o_pc    = q_pc[head];

  assign cons = o_valid & ~i_stall & ~i_redirect;

  // Stale outstanding responses still need a landing slot's worth of budget,
  // so they count against the cap. A head consumed this cycle frees its slot
  // for an allocation in the same cycle.
  assign occ        = {2'b00, count} + {2'b00, drop_cnt} - {{(CW + 1){1'b0}}, cons};
  assign o_imem_req = ~i_rst & ~halted & ~i_redirect & (occ < CAP);
  assign o_imem_addr = fetch_pc & ~32'h3;

  assign accept = o_imem_req & i_imem_ready;
  assign fill   = i_imem_rvalid & (drop_cnt == '0);

  // Control state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
      halted   <= 1'b0;
      q_filled <= '0;
    end else if (i_redirect) begin
      // Every unfilled entry still has a response in flight; those become
      // stale. A response arriving this very cycle settles one of them.
      fetch_pc <= i_redirect_pc & ~32'h3;
      tail     <= head;
      fill_ptr <= head;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= drop_cnt + pend_cnt - CW'(i_imem_rvalid);
      halted   <= 1'b0;
    end else begin
      if (accept) begin
        q_filled[tail] <= 1'b0;
        tail           <= ptr_inc(tail);
        fetch_pc       <= fetch_pc + 32'd4;
      end
      // fill_ptr never equals the tail allocated this cycle: a response
      // always belongs to an entry allocated in an earlier cycle.
      if (i_imem_rvalid) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - 1'b1;
        end else begin
          q_filled[fill_ptr] <= 1'b1;
          fill_ptr           <= ptr_inc(fill_ptr);
        end
      end
      if (cons) begin
        head <= ptr_inc(head);
      end
      count    <= count + CW'(accept) - CW'(cons);
      pend_cnt <= pend_cnt + CW'(accept) - CW'(fill);
      if (i_halt & cons) begin
        halted <= 1'b1;
      end
    end
  end

  // Queue payload; validity is carried by count/q_filled, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_redirect) begin
      if (accept) begin
        q_pc[tail] <= fetch_pc;
      end
      if (fill) begin
        q_inst[fill_ptr] <= i_imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int          QDEPTH    = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'h0010_0073;

  logic        i_clk;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_valid;

  fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr),
    .i_imem_ready(i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata(i_imem_rdata),
    .i_stall(i_stall),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_halt(i_halt),
    .o_inst(o_inst),
    .o_pc(o_pc),
    .o_valid(o_valid)
  );

  // ---------------------------------------------------------------- clock/reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------- model state
  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];     // requests memory has accepted, oldest first
  logic [31:0] exp_q[$];     // PCs decode must see next, oldest first
  int          live_resp;    // answered, current-epoch words not yet consumed
  int          epoch;
  int          cyc;
  int          deliveries;
  int          lat_min;
  int          lat_max;
  bit          mdl_halted;
  logic [31:0] exp_req_addr;
  logic [31:0] halt_at;

  int n_checks;
  int n_fail;

  bit          drv_rst;
  bit          drv_stall;
  bit          drv_redirect;
  bit          drv_ready;
  logic [31:0] drv_rpc;

  logic        ob_valid;
  logic        ob_req;
  logic        ob_cons;
  logic [31:0] ob_pc;
  logic [31:0] ob_inst;
  logic [31:0] ob_addr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == halt_at) ? HALT_WORD : (a ^ 32'hC3A5_0F01);
  endfunction

  function automatic int live_outstanding();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- driver + scoreboard
  // One clock cycle: drive inputs at the falling edge, check outputs, then
  // advance the model to what the next rising edge should commit.
  task automatic cycle();
    int  occ;
    bit  mdl_valid;
    bit  mdl_cons;
    bit  exp_req;
    @(negedge i_clk);
    i_rst         = drv_rst;
    i_stall       = drv_stall;
    i_redirect    = drv_redirect;
    i_redirect_pc = drv_rpc;
    i_imem_ready  = drv_ready;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    if (!drv_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = word_at(mem_q[0].addr);
    end
    i_halt = 1'b0;
    #1;
    i_halt = o_valid && (o_inst == HALT_WORD);
    #1;
    ob_valid = o_valid;
    ob_req   = o_imem_req;
    ob_pc    = o_pc;
    ob_inst  = o_inst;
    ob_addr  = o_imem_addr;
    ob_cons  = o_valid & ~drv_stall & ~drv_redirect;

    if (drv_rst) begin
      check("rst_valid", {31'b0, o_valid}, 32'd0);
      check("rst_req", {31'b0, o_imem_req}, 32'd0);
      mem_q.delete();
      exp_q.delete();
      live_resp    = 0;
      epoch++;
      mdl_halted   = 1'b0;
      exp_req_addr = RESET_PC & ~32'h3;
    end else begin
      mdl_valid = (live_resp > 0);
      mdl_cons  = mdl_valid && !drv_stall && !drv_redirect;
      occ       = mem_q.size() + live_resp;
      exp_req   = !mdl_halted && !drv_redirect && (occ - int'(mdl_cons) < QDEPTH);

      check("valid", {31'b0, o_valid}, {31'b0, mdl_valid});
      if (mdl_valid) begin
        check("out_pc", o_pc, exp_q[0]);
        check("out_inst", o_inst, word_at(exp_q[0]));
      end
      check("req", {31'b0, o_imem_req}, {31'b0, exp_req});
      if (exp_req) check("req_addr", o_imem_addr, exp_req_addr);

      if (exp_req && drv_ready) begin
        mem_q.push_back('{exp_req_addr, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
        exp_q.push_back(exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (i_imem_rvalid) begin
        if (mem_q[0].epoch == epoch) live_resp++;
        void'(mem_q.pop_front());
      end
      if (mdl_cons) begin
        if (word_at(exp_q[0]) == HALT_WORD) mdl_halted = 1'b1;
        void'(exp_q.pop_front());
        live_resp--;
        deliveries++;
      end
      if (drv_redirect) begin
        epoch++;
        live_resp    = 0;
        exp_q.delete();
        exp_req_addr = drv_rpc & ~32'h3;
        mdl_halted   = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    drv_redirect = 1'b1;
    drv_rpc      = pc;
    cycle();
    drv_redirect = 1'b0;
  endtask

  task automatic wait_cons(input string tag, input logic [31:0] exp_pc);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (ob_cons) got = 1'b1;
    end
    check({tag, "_seen"}, {31'b0, got}, 32'd1);
    if (got) check(tag, ob_pc, exp_pc);
  endtask

  function automatic logic [31:0] wrap_exp(input int k);
    case (k)
      0:       return 32'hFFFF_FFF8;
      1:       return 32'hFFFF_FFFC;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit got;
    int k;
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    epoch        = 0;
    live_resp    = 0;
    deliveries   = 0;
    mdl_halted   = 1'b0;
    halt_at      = 32'hFFFF_FFFF;
    lat_min      = 1;
    lat_max      = 1;
    exp_req_addr = RESET_PC & ~32'h3;
    drv_rst      = 1'b1;
    drv_stall    = 1'b0;
    drv_redirect = 1'b0;
    drv_ready    = 1'b1;
    drv_rpc      = 32'h0;

    cycle();
    cycle();
    drv_rst = 1'b0;

    // Streaming from reset with single-cycle memory.
    cycle();
    check("t1_c0_valid", {31'b0, ob_valid}, 32'd0);
    check("t1_c0_addr", ob_addr, RESET_PC);
    check("t1_c0_req", {31'b0, ob_req}, 32'd1);
    cycle();
    check("t1_c1_valid", {31'b0, ob_valid}, 32'd0);
    check("t1_c1_addr", ob_addr, RESET_PC + 32'h4);
    cycle();
    check("t1_c2_valid", {31'b0, ob_valid}, 32'd1);
    check("t1_c2_pc", ob_pc, RESET_PC);
    check("t1_c2_addr", ob_addr, RESET_PC + 32'h8);
    cycle();
    check("t1_c3_pc", ob_pc, RESET_PC + 32'h4);

    // Stall with 0x8 at the output.
    drv_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_valid", {31'b0, ob_valid}, 32'd1);
      check("stall_pc", ob_pc, RESET_PC + 32'h8);
    end
    drv_stall = 1'b0;
    cycle();
    check("unstall_pc", ob_pc, RESET_PC + 32'h8);
    cycle();
    check("resume_pc", ob_pc, RESET_PC + 32'hC);

    // Redirect with two slow requests still unanswered.
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    lat_min = 3;
    lat_max = 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (live_outstanding() >= 2) got = 1'b1;
    end
    check("two_outstanding", {31'b0, got}, 32'd1);
    do_redirect(32'h0000_0100);
    wait_cons("redir_pc", 32'h0000_0100);

    // Unaligned redirect coinciding with a response.
    lat_min = 1;
    lat_max = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) got = 1'b1;
      else cycle();
    end
    do_redirect(32'h0000_0203);
    cycle();
    check("unaligned_req", {31'b0, ob_req}, 32'd1);
    check("unaligned_addr", ob_addr, 32'h0000_0200);
    wait_cons("unaligned_pc", 32'h0000_0200);

    // Halt at 0x10, then restart through a redirect.
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    halt_at = 32'h0000_0010;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (ob_cons && ob_pc == 32'h0000_0010) got = 1'b1;
    end
    check("halt_seen", {31'b0, got}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("halt_noreq", {31'b0, ob_req}, 32'd0);
    end
    do_redirect(32'h0000_0040);
    cycle();
    check("unhalt_req", {31'b0, ob_req}, 32'd1);
    check("unhalt_addr", ob_addr, 32'h0000_0040);
    wait_cons("unhalt_pc", 32'h0000_0040);
    halt_at = 32'hFFFF_FFFF;

    // Address wrap at the top of memory, then reset mid-stream.
    do_redirect(32'hFFFF_FFF8);
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      cycle();
      if (ob_req) begin
        check("wrap_addr", ob_addr, wrap_exp(k));
        k++;
      end
    end
    check("wrap_count", k, 32'd3);
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    cycle();
    check("post_rst_valid", {31'b0, ob_valid}, 32'd0);
    check("post_rst_req", {31'b0, ob_req}, 32'd1);
    check("post_rst_addr", ob_addr, RESET_PC);

    // Randomized traffic.
    halt_at = 32'h0000_0088;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      drv_rst      = ($urandom_range(299, 0) == 0);
      drv_stall    = ($urandom_range(3, 0) == 0);
      drv_ready    = ($urandom_range(9, 0) < 7);
      drv_redirect = ($urandom_range(39, 0) == 0);
      if ($urandom_range(9, 0) == 0) drv_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else drv_rpc = 32'($urandom_range(1023, 0));
      cycle();
    end
    drv_rst      = 1'b0;
    drv_stall    = 1'b0;
    drv_redirect = 1'b0;
    drv_ready    = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    check("progress", {31'b0, deliveries >= 300}, 32'd1);

    // ---------------------------------------------------------------- report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
